fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction fetch front end. Produces the decode-stage instruction stream (instn_vld_id, instn_pc_id, instn_opcode_id) that the issue/graduation unit consumes under its i_issue_id handshake.
- Consumes that unit's fetch-redirect output (redir_vld_xx, redir_addr_xx).
- Issues sequential 32-bit instruction reads to an in-order instruction memory port and buffers returned opcodes in a small queue.
- Cancels in-flight reads on redirect.

Parameters:
- DEPTH, 4: instruction queue entries; also the cap on queued + in-flight reads. Power of two, at least 2.

Ports:
- clk  in  1  core clock
- reset_n  in  1  reset, asynchronous, active-low
- redir_vld_xx  in  1  redirect request from graduation
- redir_addr_xx  in  64  redirect target PC
- imem_req_vld  out  1  read request valid
- imem_req_rdy  in  1  memory accepts request
- imem_req_addr  out  64  read address, bits [1:0] always 0
- imem_rsp_vld  in  1  read data valid; responses return in request order, one per accepted request
- imem_rsp_data  in  32  opcode
- instn_vld_id  out  1  queue head valid
- instn_pc_id  out  64  head PC
- instn_opcode_id  out  32  head opcode
- i_issue_id  in  1  head consumed this cycle; only meaningful when instn_vld_id=1

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-low. All state is cleared asynchronously on reset_n=0.
- Reset values:
  - state=IDLE; outputs imem_req_vld=0, instn_vld_id=0.
  - fetch_pc, rsp_pc, imem_req_addr, instn_pc_id and instn_opcode_id = 0.
  - Queue count, outstanding and drop_cnt = 0.
- States:
  - IDLE: no requests are issued. Leaves only on redir_vld_xx=1 (graduation supplies the reset vector this way).
  - RUN: fetching. Never returns to IDLE except through reset.
- Addresses:
  - On redir_vld_xx, fetch_pc and rsp_pc load {redir_addr_xx[63:2],2'b00}.
  - imem_req_addr = fetch_pc.
  - fetch_pc += 4 on each request handshake (imem_req_vld & imem_req_rdy); it wraps modulo 2^64.
- Request gating:
  - imem_req_vld = (state==RUN) & ~redir_vld_xx & (count + outstanding < DEPTH).
  - A request offered while imem_req_rdy=0 is held stable.
  - outstanding increments on a request handshake and decrements on imem_rsp_vld.
- Responses:
  - If drop_cnt>0, the response is discarded and drop_cnt decrements.
  - Otherwise {rsp_pc, imem_rsp_data} is pushed into the queue and rsp_pc += 4.
  - Credit gating guarantees the queue never overflows. A response arriving with outstanding==0 is a protocol error and is ignored.
- Decode side:
  - instn_vld_id = (count!=0).
  - instn_pc_id and instn_opcode_id come combinationally from the queue head.
  - The head pops when instn_vld_id & i_issue_id.
  - Push and pop in the same cycle keeps count unchanged; a push into an empty queue is visible the next cycle (1-cycle response-to-decode latency).
- Redirect (highest priority):
  - The queue is flushed (count=0 next cycle); any pop or push in that cycle is ignored.
  - drop_cnt <= outstanding + (request handshake this cycle ? 1 : 0) − (imem_rsp_vld ? 1 : 0), where outstanding and drop_cnt are their current-cycle values; if drop_cnt was already nonzero, the new value includes those pending drops.
  - No request is issued in the redirect cycle. Fetching at the new PC starts the next cycle.
- Back-to-back redirects: each redirect recomputes drop_cnt and reloads fetch_pc and rsp_pc; the last redirect wins.

Optional Feature:
- Macro: FETCH_PERF_EN.
- Defined: adds output ports perf_fetched (32 bits: responses pushed) and perf_dropped (32 bits: responses discarded). Both are reset to 0, saturate at all-ones and are unaffected by redirect.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package fetch_pkg:
  - fetch_state_t enum {IDLE, RUN}
  - fetch_entry_t struct {pc[63:0], opcode[31:0]}
  - FETCH_DEPTH_DEFAULT=4
- Sub-module fetch_queue: circular buffer of fetch_entry_t with push, pop, flush, count and head output.
- Credit, drop and PC logic stay in fetch_unit.

Test Plan:
- Reset then redirect to 0x20000 with imem_req_rdy=1 and 1-cycle memory latency: requests 0x20000, 0x20004, 0x20008, 0x2000C issued; with i_issue_id=0, the request count stops at 4 and instn_pc_id=0x20000.
- Steady stream with i_issue_id=1 every cycle: consecutive PCs +4, opcodes match memory, no gaps after fill.
- Redirect to 0x40002 with 3 reads in flight: next 3 responses discarded, queue empty next cycle, first delivered instn_pc_id=0x40000.
- Redirect in the same cycle as a pop and a response: queue flushed, that response counted in neither queue nor drop_cnt, no request issued that cycle.
- imem_req_rdy=0 for 5 cycles: imem_req_addr held stable, fetch_pc unchanged; assert reset_n=0 mid-stream and confirm all outputs clear immediately.
- With FETCH_PERF_EN: after the redirect scenario, perf_dropped=3 and perf_fetched equals the number of delivered instructions.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
package fetch_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] opcode;
  } fetch_entry_t;

  localparam int FETCH_DEPTH_DEFAULT = 4;

  // Instructions are word aligned; the low two address bits are forced to zero.
  function automatic logic [63:0] align_pc(input logic [63:0] addr);
    return addr & ~64'd3;
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Circular buffer of fetched instructions with push, pop, flush and a
// combinational head. Flush wins over push and pop in the same cycle.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = FETCH_DEPTH_DEFAULT,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         push_i,
  input  fetch_entry_t push_data_i,
  input  logic         pop_i,
  input  logic         flush_i,
  output logic [CW-1:0] count_o,
  output fetch_entry_t head_o
);

  localparam int AW = $clog2(DEPTH);

  fetch_entry_t    mem_q [DEPTH];
  logic [AW-1:0]   rd_ptr_q;
  logic [AW-1:0]   wr_ptr_q;
  logic [CW-1:0]   count_q;
  logic            do_push;
  logic            do_pop;

  assign do_pop  = pop_i  & (count_q != '0)          & ~flush_i;
  assign do_push = push_i & (count_q != CW'(DEPTH))  & ~flush_i;

  // Pointer and occupancy tracking; a flush empties the ring at once.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // Entry storage, written only on an accepted push.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

  // An empty queue presents zeros so the decode outputs are clean after reset.
  assign head_o  = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
  assign count_o = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: sequential word reads, credit-limited so the
// queue can never overflow, with redirect-time cancellation of in-flight
// reads via a drop counter. Define FETCH_PERF_EN to add the perf_fetched /
// perf_dropped saturating counters and their ports.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int DEPTH = FETCH_DEPTH_DEFAULT
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        redir_vld_xx,
  input  logic [63:0] redir_addr_xx,
  output logic        imem_req_vld,
  input  logic        imem_req_rdy,
  output logic [63:0] imem_req_addr,
  input  logic        imem_rsp_vld,
  input  logic [31:0] imem_rsp_data,
  output logic        instn_vld_id,
  output logic [63:0] instn_pc_id,
  output logic [31:0] instn_opcode_id,
`ifdef FETCH_PERF_EN
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_dropped,
`endif
  input  logic        i_issue_id
);

  localparam int CW = $clog2(DEPTH) + 1;
  typedef logic [CW:0] credit_t;

  fetch_state_t  state_q, state_d;
  logic [63:0]   fetch_pc_q, fetch_pc_d;
  logic [63:0]   rsp_pc_q, rsp_pc_d;
  logic [CW-1:0] outstanding_q, outstanding_d;
  logic [CW-1:0] drop_cnt_q, drop_cnt_d;

  logic [CW-1:0] q_count;
  fetch_entry_t  q_head;
  fetch_entry_t  q_push_data;
  logic          q_push;
  logic          q_pop;
  logic          credit_ok;
  logic          req_hs;
  logic          rsp_ok;

  // Queued plus in-flight reads may never exceed the queue capacity.
  assign credit_ok = (credit_t'(q_count) + credit_t'(outstanding_q)) < credit_t'(DEPTH);
  assign req_hs    = imem_req_vld & imem_req_rdy;
  // A response with nothing outstanding is a protocol error and is ignored.
  assign rsp_ok    = imem_rsp_vld & (outstanding_q != '0);

  assign q_push      = rsp_ok & ~redir_vld_xx & (drop_cnt_q == '0);
  assign q_pop       = instn_vld_id & i_issue_id;
  assign q_push_data = '{pc: rsp_pc_q, opcode: imem_rsp_data};

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next state and request valid; a redirect cycle never issues a request.
  always_comb begin
    state_d      = state_q;
    imem_req_vld = 1'b0;
    case (state_q)
      IDLE: if (redir_vld_xx) state_d = RUN;
      RUN:  imem_req_vld = ~redir_vld_xx & credit_ok;
      default: state_d = IDLE;
    endcase
  end

  // PC, credit and drop bookkeeping; a redirect turns every read still in
  // flight after this cycle into a read to be discarded.
  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    rsp_pc_d      = rsp_pc_q;
    drop_cnt_d    = drop_cnt_q;
    outstanding_d = outstanding_q + CW'(req_hs) - CW'(rsp_ok);
    if (redir_vld_xx) begin
      fetch_pc_d = align_pc(redir_addr_xx);
      rsp_pc_d   = align_pc(redir_addr_xx);
      drop_cnt_d = outstanding_d;
    end else begin
      if (req_hs) fetch_pc_d = fetch_pc_q + 64'd4;
      if (rsp_ok) begin
        if (drop_cnt_q != '0) drop_cnt_d = drop_cnt_q - 1'b1;
        else                  rsp_pc_d   = rsp_pc_q + 64'd4;
      end
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fetch_pc_q    <= '0;
      rsp_pc_q      <= '0;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      rsp_pc_q      <= rsp_pc_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
    end
  end

  fetch_queue #(
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_queue (
    .clk         (clk),
    .reset_n     (reset_n),
    .push_i      (q_push),
    .push_data_i (q_push_data),
    .pop_i       (q_pop),
    .flush_i     (redir_vld_xx),
    .count_o     (q_count),
    .head_o      (q_head)
  );

  assign imem_req_addr   = fetch_pc_q;
  assign instn_vld_id    = (q_count != '0);
  assign instn_pc_id     = q_head.pc;
  assign instn_opcode_id = q_head.opcode;

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched_q;
  logic [31:0] perf_dropped_q;
  logic        rsp_discard;

  // Every accepted response is either pushed or discarded.
  assign rsp_discard = rsp_ok & ~q_push;

  // Saturating event counters, untouched by redirect.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_fetched_q <= '0;
      perf_dropped_q <= '0;
    end else begin
      if (q_push && perf_fetched_q != '1)      perf_fetched_q <= perf_fetched_q + 32'd1;
      if (rsp_discard && perf_dropped_q != '1) perf_dropped_q <= perf_dropped_q + 32'd1;
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_dropped = perf_dropped_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a directed vector table, hand-written
// redirect / stall / reset sequences, and a randomized run, all compared
// against a queue-based reference model and an in-order memory model.
module tb_fetch_unit;
  import fetch_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        redir_vld_xx = 1'b0;
  logic [63:0] redir_addr_xx = '0;
  logic        imem_req_vld;
  logic        imem_req_rdy = 1'b0;
  logic [63:0] imem_req_addr;
  logic        imem_rsp_vld = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        instn_vld_id;
  logic [63:0] instn_pc_id;
  logic [31:0] instn_opcode_id;
  logic        i_issue_id = 1'b0;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_dropped;
`endif

  always #5 clk = ~clk;

  fetch_unit #(.DEPTH(DEPTH)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .redir_vld_xx    (redir_vld_xx),
    .redir_addr_xx   (redir_addr_xx),
    .imem_req_vld    (imem_req_vld),
    .imem_req_rdy    (imem_req_rdy),
    .imem_req_addr   (imem_req_addr),
    .imem_rsp_vld    (imem_rsp_vld),
    .imem_rsp_data   (imem_rsp_data),
    .instn_vld_id    (instn_vld_id),
    .instn_pc_id     (instn_pc_id),
    .instn_opcode_id (instn_opcode_id),
`ifdef FETCH_PERF_EN
    .perf_fetched    (perf_fetched),
    .perf_dropped    (perf_dropped),
`endif
    .i_issue_id      (i_issue_id)
  );

  // ---------------- reference model state ----------------
  typedef struct {
    logic [63:0] addr;
    bit          stale;
    int          due;
  } pend_t;

  pend_t        pend[$];      // reads accepted by memory, oldest first
  fetch_entry_t mq[$];        // instructions visible to decode, head first
  bit           m_run;
  logic [63:0]  m_fetch;
  bit           m_ereq;
  int unsigned  m_fetched, m_dropped;
  int           cyc;
  int           mem_lat = 1;
  bit           rsp_en = 1'b1;
  int           tests = 0;
  int           fails = 0;

  function automatic logic [31:0] mem_f(input logic [63:0] a);
    return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", nm, cyc, act, exp);
    end
  endtask

  // Drive inputs for this cycle (called just after a falling edge) and
  // compare DUT outputs against the model.
  task automatic apply(input bit redir, input logic [63:0] raddr, input bit rdy, input bit issue);
    redir_vld_xx  = redir;
    redir_addr_xx = raddr;
    imem_req_rdy  = rdy;
    i_issue_id    = issue;
    if (rsp_en && pend.size() != 0 && pend[0].due <= cyc) begin
      imem_rsp_vld  = 1'b1;
      imem_rsp_data = mem_f(pend[0].addr);
    end else begin
      imem_rsp_vld  = 1'b0;
      imem_rsp_data = $urandom();
    end
    #2;
    m_ereq = m_run && !redir && ((mq.size() + pend.size()) < DEPTH);
    chk("imem_req_vld", {63'd0, imem_req_vld}, {63'd0, m_ereq});
    chk("imem_req_addr", imem_req_addr, m_fetch);
    chk("instn_vld_id", {63'd0, instn_vld_id}, {63'd0, mq.size() != 0});
    if (mq.size() != 0) begin
      chk("instn_pc_id", instn_pc_id, mq[0].pc);
      chk("instn_opcode_id", {32'd0, instn_opcode_id}, {32'd0, mq[0].opcode});
    end
`ifdef FETCH_PERF_EN
    chk("perf_fetched", {32'd0, perf_fetched}, {32'd0, m_fetched});
    chk("perf_dropped", {32'd0, perf_dropped}, {32'd0, m_dropped});
`endif
  endtask

  // Clock edge: advance memory and model by one cycle.
  task automatic advance();
    bit    pop, hs, rsp;
    pend_t f;
    pop = (mq.size() != 0) && i_issue_id;
    hs  = m_ereq && imem_req_rdy;
    rsp = imem_rsp_vld;
    @(posedge clk);
    if (rsp) f = pend.pop_front();
    if (redir_vld_xx) begin
      mq.delete();
      foreach (pend[i]) pend[i].stale = 1'b1;
      m_fetch = redir_addr_xx & ~64'd3;
      m_run   = 1'b1;
      if (rsp) m_dropped++;
    end else begin
      if (pop) mq.delete(0);
      if (rsp) begin
        if (f.stale) m_dropped++;
        else begin
          mq.push_back('{pc: f.addr, opcode: mem_f(f.addr)});
          m_fetched++;
        end
      end
      if (hs) begin
        pend.push_back('{addr: m_fetch, stale: 1'b0, due: cyc + mem_lat});
        m_fetch += 64'd4;
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear without a clock.
  task automatic do_reset();
    #1;
    reset_n = 1'b0;
    #1;
    chk("rst imem_req_vld", {63'd0, imem_req_vld}, 64'd0);
    chk("rst imem_req_addr", imem_req_addr, 64'd0);
    chk("rst instn_vld_id", {63'd0, instn_vld_id}, 64'd0);
    chk("rst instn_pc_id", instn_pc_id, 64'd0);
    chk("rst instn_opcode_id", {32'd0, instn_opcode_id}, 64'd0);
`ifdef FETCH_PERF_EN
    chk("rst perf_fetched", {32'd0, perf_fetched}, 64'd0);
    chk("rst perf_dropped", {32'd0, perf_dropped}, 64'd0);
`endif
    pend.delete();
    mq.delete();
    m_run = 1'b0; m_fetch = '0; m_fetched = 0; m_dropped = 0;
    redir_vld_xx = 1'b0; imem_req_rdy = 1'b0; imem_rsp_vld = 1'b0; i_issue_id = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  // Directed vector: inputs and hand-derived expectations per cycle.
  typedef struct {
    bit          redir;
    logic [63:0] raddr;
    bit          rdy;
    bit          issue;
    bit          e_req;
    logic [63:0] e_addr;
    bit          e_vld;
    logic [63:0] e_pc;
  } vec_t;

  vec_t tbl[13];

  initial begin
    int          nrsp;
    bit          seen;
    logic [63:0] held;
    logic [63:0] a;
`ifdef FETCH_PERF_EN
    int unsigned drop_base;
`endif

    // Redirect to 0x20000, fill with issue held off, then stream at one per cycle.
    tbl[0]  = '{1, 64'h20000, 1, 0, 0, 64'h0,     0, 64'h0};
    tbl[1]  = '{0, 64'h0,     1, 0, 1, 64'h20000, 0, 64'h0};
    tbl[2]  = '{0, 64'h0,     1, 0, 1, 64'h20004, 0, 64'h0};
    tbl[3]  = '{0, 64'h0,     1, 0, 1, 64'h20008, 1, 64'h20000};
    tbl[4]  = '{0, 64'h0,     1, 0, 1, 64'h2000C, 1, 64'h20000};
    tbl[5]  = '{0, 64'h0,     1, 0, 0, 64'h20010, 1, 64'h20000};
    tbl[6]  = '{0, 64'h0,     1, 0, 0, 64'h20010, 1, 64'h20000};
    tbl[7]  = '{0, 64'h0,     1, 1, 0, 64'h20010, 1, 64'h20000};
    tbl[8]  = '{0, 64'h0,     1, 1, 1, 64'h20010, 1, 64'h20004};
    tbl[9]  = '{0, 64'h0,     1, 1, 1, 64'h20014, 1, 64'h20008};
    tbl[10] = '{0, 64'h0,     1, 1, 1, 64'h20018, 1, 64'h2000C};
    tbl[11] = '{0, 64'h0,     1, 1, 1, 64'h2001C, 1, 64'h20010};
    tbl[12] = '{0, 64'h0,     1, 1, 1, 64'h20020, 1, 64'h20014};

    cyc = 0;
    m_run = 1'b0; m_fetch = '0; m_fetched = 0; m_dropped = 0;
    @(negedge clk);
    do_reset();

    // IDLE must not fetch before the first redirect.
    for (int i = 0; i < 3; i++) begin
      apply(0, 64'h0, 1, 1);
      chk("idle imem_req_vld", {63'd0, imem_req_vld}, 64'd0);
      advance();
    end

    for (int i = 0; i < 13; i++) begin
      apply(tbl[i].redir, tbl[i].raddr, tbl[i].rdy, tbl[i].issue);
      chk($sformatf("vec%0d req_vld", i), {63'd0, imem_req_vld}, {63'd0, tbl[i].e_req});
      chk($sformatf("vec%0d req_addr", i), imem_req_addr, tbl[i].e_addr);
      chk($sformatf("vec%0d instn_vld", i), {63'd0, instn_vld_id}, {63'd0, tbl[i].e_vld});
      if (tbl[i].e_vld) begin
        chk($sformatf("vec%0d instn_pc", i), instn_pc_id, tbl[i].e_pc);
        chk($sformatf("vec%0d opcode", i), {32'd0, instn_opcode_id}, {32'd0, mem_f(tbl[i].e_pc)});
      end
      advance();
    end

    // Redirect to 0x40002 with exactly three reads in flight.
    rsp_en = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (pend.size() == 3) begin seen = 1'b1; break; end
      apply(0, 64'h0, 1, 1);
      advance();
    end
    chk("reach 3 in flight", {63'd0, seen}, 64'd1);
`ifdef FETCH_PERF_EN
    drop_base = perf_dropped;
`endif
    apply(1, 64'h40002, 1, 1);
    chk("redir no request", {63'd0, imem_req_vld}, 64'd0);
    advance();
    rsp_en = 1'b1;
    mem_lat = 1;
    apply(0, 64'h0, 1, 0);
    chk("redir flush", {63'd0, instn_vld_id}, 64'd0);
    nrsp = 0; seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (instn_vld_id) begin seen = 1'b1; break; end
      if (imem_rsp_vld) nrsp++;
      advance();
      apply(0, 64'h0, 1, 0);
    end
    chk("redir first delivery", {63'd0, seen}, 64'd1);
    chk("redir first pc", instn_pc_id, 64'h40000);
    chk("redir responses before delivery", 64'(nrsp), 64'd4);
`ifdef FETCH_PERF_EN
    chk("perf dropped by redirect", 64'(perf_dropped - drop_base), 64'd3);
`endif
    advance();

    // Redirect coinciding with a pop and a response.
    for (int i = 0; i < 6; i++) begin apply(0, 64'h0, 1, 1); advance(); end
    apply(1, 64'h60000, 1, 1);
    chk("redir+rsp precondition", {63'd0, imem_rsp_vld}, 64'd1);
    chk("redir+pop head valid", {63'd0, instn_vld_id}, 64'd1);
    chk("redir+rsp no request", {63'd0, imem_req_vld}, 64'd0);
    advance();
    apply(0, 64'h0, 1, 1);
    chk("redir+rsp flushed", {63'd0, instn_vld_id}, 64'd0);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      advance();
      apply(0, 64'h0, 1, 1);
      if (instn_vld_id) begin seen = 1'b1; break; end
    end
    chk("redir+rsp delivery", {63'd0, seen}, 64'd1);
    chk("redir+rsp first pc", instn_pc_id, 64'h60000);
    advance();

    // Memory not ready for five cycles: request held, address stable.
    for (int i = 0; i < 4; i++) begin apply(0, 64'h0, 1, 1); advance(); end
    apply(0, 64'h0, 0, 1);
    held = imem_req_addr;
    chk("stall req offered", {63'd0, imem_req_vld}, 64'd1);
    advance();
    for (int i = 1; i < 5; i++) begin
      apply(0, 64'h0, 0, 1);
      chk("stall req held", {63'd0, imem_req_vld}, 64'd1);
      chk("stall addr held", imem_req_addr, held);
      advance();
    end
    apply(0, 64'h0, 1, 1);
    chk("stall resume addr", imem_req_addr, held);
    advance();
    apply(0, 64'h0, 1, 1);
    chk("stall next addr", imem_req_addr, held + 64'd4);
    advance();

    // Reset in the middle of a stream.
    do_reset();

    // Address wrap near the top of the address space.
    apply(1, 64'hFFFF_FFFF_FFFF_FFF9, 1, 0);
    advance();
    for (int i = 0; i < 8; i++) begin apply(0, 64'h0, 1, 1); advance(); end

    // Randomized traffic against the model.
    for (int n = 0; n < 2000; n++) begin
      if ($urandom_range(0, 3) == 0) a = 64'hFFFF_FFFF_FFFF_FFE0 | 64'($urandom_range(0, 31));
      else                           a = {$urandom(), $urandom()};
      rsp_en = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 49) == 0) mem_lat = $urandom_range(1, 4);
      apply($urandom_range(0, 39) == 0, a, $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0);
      advance();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
